// File: rtl/time_gen_multi.sv
// Divides clk256 into one-cycle second/minute/hour strobes with running second and minute counts.
// Adds count enable, synchronous restart and a fast mode with a smaller prescale period.
module time_gen_multi #(
    parameter int unsigned CLK_DIV       = 256,
    parameter int unsigned FAST_DIV      = 4,
    parameter int unsigned SECS_PER_MIN  = 60,
    parameter int unsigned MINS_PER_HOUR = 60,
    localparam int unsigned PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1,
    localparam int unsigned SEC_W = (SECS_PER_MIN > 2) ? $clog2(SECS_PER_MIN) : 1,
    localparam int unsigned MIN_W = (MINS_PER_HOUR > 2) ? $clog2(MINS_PER_HOUR) : 1
) (
    input  logic             clk256,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             fast_mode,
    output logic             one_second,
    output logic             one_minute,
    output logic             one_hour,
    output logic [SEC_W-1:0] sec_count,
    output logic [MIN_W-1:0] min_count
);

    localparam logic [PRE_W-1:0] ClkLast  = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] FastLast = PRE_W'(FAST_DIV - 1);
    localparam logic [SEC_W-1:0] SecLast  = SEC_W'(SECS_PER_MIN - 1);
    localparam logic [MIN_W-1:0] MinLast  = MIN_W'(MINS_PER_HOUR - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic             sec_stb_q, sec_stb_d;
    logic             min_stb_q, min_stb_d;
    logic             hour_stb_q, hour_stb_d;

    logic [PRE_W-1:0] pre_last;
    logic             pre_term;

    // Magnitude compare so a switch into fast mode with pre past the new terminal wraps at once.
    assign pre_last = fast_mode ? FastLast : ClkLast;
    assign pre_term = (pre_q >= pre_last);

    always_comb begin
        pre_d      = pre_q;
        sec_d      = sec_q;
        min_d      = min_q;
        sec_stb_d  = 1'b0;
        min_stb_d  = 1'b0;
        hour_stb_d = 1'b0;
        if (sync) begin
            pre_d = '0;
            sec_d = '0;
            min_d = '0;
        end else if (enable) begin
            if (pre_term) begin
                pre_d     = '0;
                sec_stb_d = 1'b1;
                if (sec_q == SecLast) begin
                    sec_d     = '0;
                    min_stb_d = 1'b1;
                    if (min_q == MinLast) begin
                        min_d      = '0;
                        hour_stb_d = 1'b1;
                    end else begin
                        min_d = min_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            pre_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            sec_stb_q  <= 1'b0;
            min_stb_q  <= 1'b0;
            hour_stb_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            sec_stb_q  <= sec_stb_d;
            min_stb_q  <= min_stb_d;
            hour_stb_q <= hour_stb_d;
        end
    end

    assign one_second = sec_stb_q;
    assign one_minute = min_stb_q;
    assign one_hour   = hour_stb_q;
    assign sec_count  = sec_q;
    assign min_count  = min_q;

endmodule
